// File: rtl/demux_capture.sv
// demux_capture: registered 1-to-WIDTH bit demultiplexer.
// This block steers the single input bit din into one position of the held word out.
// The position is either the auto-increment pointer ptr or the addressed index sel.
// An internal mask records which positions have been written since the last clear or ack.
// When every position has been written, the block reports a complete word on word_valid.
// Optional feature: define DEMUX_CAPTURE_PARITY_EN to add a registered parity output.
// That output is the XOR-reduction of out.
//
// Handshake:
// - The producer side uses wr_en and wr_ready.
//   A write is accepted on a rising edge where wr_en=1 and wr_ready=1.
//   wr_en is ignored while wr_ready=0.
// - The consumer side uses word_valid and rd_ack.
//   word_valid stays high until rd_ack is sampled high on a rising edge.
//   That edge releases the word and reopens the write side.
//   rd_ack while word_valid=0 has no effect.
module demux_capture #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic             auto_mode,
  input  logic             clear,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] out,
  output logic [SEL_W-1:0] ptr,
  output logic             wr_ready,
  output logic             word_valid
`ifdef DEMUX_CAPTURE_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] mask_n;
  logic [WIDTH-1:0] out_n;
  logic [SEL_W-1:0] ptr_n;
  logic [SEL_W-1:0] idx;
  logic             wr_accept;

  assign wr_accept = wr_en & wr_ready;
  assign idx       = auto_mode ? ptr : sel;

  // Datapath next values, resolved in priority order: clear, then ack in FULL, then write.
  always_comb begin
    out_n  = out;
    mask_n = mask;
    ptr_n  = ptr;
    if (clear) begin
      out_n  = '0;
      mask_n = '0;
      ptr_n  = '0;
    end else if (rd_ack && state == FULL) begin
      // out is deliberately held so the consumer can still sample the completed word.
      mask_n = '0;
      ptr_n  = '0;
    end else if (wr_accept) begin
      out_n[idx]  = din;
      mask_n[idx] = 1'b1;
      if (auto_mode) begin
        ptr_n = ptr + SEL_W'(1);
      end
    end
  end

  // Next state comes purely from the next mask, so word_valid rises on the completing edge.
  always_comb begin
    state_n = FILL;
    if (mask_n == '0) begin
      state_n = EMPTY;
    end else if (mask_n == {WIDTH{1'b1}}) begin
      state_n = FULL;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      mask  <= '0;
      out   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      out   <= out_n;
      ptr   <= ptr_n;
    end
  end

  // Handshake flags decoded from the registered state.
  always_comb begin
    wr_ready   = (state != FULL);
    word_valid = (state == FULL);
  end

`ifdef DEMUX_CAPTURE_PARITY_EN
  // Parity is registered from the next word so it changes on the same edge as out.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ^out_n;
    end
  end
`endif

endmodule

// File: tb/tb_demux_capture.sv
// tb_demux_capture: directed testbench for demux_capture.
// Each write pushes the word expected after that edge onto a queue.
// The queue entry is popped and compared once the edge has passed.
// Parity checks are included when DEMUX_CAPTURE_PARITY_EN is defined.
module tb_demux_capture;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  logic             clk;
  logic             rst;
  logic             din;
  logic [SEL_W-1:0] sel;
  logic             wr_en;
  logic             auto_mode;
  logic             clear;
  logic             rd_ack;
  logic [WIDTH-1:0] out;
  logic [SEL_W-1:0] ptr;
  logic             wr_ready;
  logic             word_valid;
`ifdef DEMUX_CAPTURE_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fill_word;
  logic [WIDTH-1:0] last_word;

  demux_capture #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .sel        (sel),
    .wr_en      (wr_en),
    .auto_mode  (auto_mode),
    .clear      (clear),
    .rd_ack     (rd_ack),
    .out        (out),
    .ptr        (ptr),
    .wr_ready   (wr_ready),
    .word_valid (word_valid)
`ifdef DEMUX_CAPTURE_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its required value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected word from the scoreboard and compare it against out.
  task automatic check_out(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, out);
    end else begin
      last_word = exp_q.pop_front();
      check(tag, 32'(out), 32'(last_word));
`ifdef DEMUX_CAPTURE_PARITY_EN
      check({tag, "_parity"}, 32'(parity), 32'(^last_word));
`endif
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic a, input logic [SEL_W-1:0] s,
                      input logic d, input logic c, input logic k);
    @(negedge clk);
    wr_en     = w;
    auto_mode = a;
    sel       = s;
    din       = d;
    clear     = c;
    rd_ack    = k;
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    clear  = 1'b0;
    rd_ack = 1'b0;
  endtask

  initial begin
    // Hold reset for two cycles with idle inputs.
    rst = 1'b1; din = 1'b0; sel = '0; wr_en = 1'b0; auto_mode = 1'b0;
    clear = 1'b0; rd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out", 32'(out), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_word_valid", 32'(word_valid), 32'h0);

    // Auto fill with 16'h3f0a, written LSB first.
    fill_word = 16'h3f0a;
    for (int i = 0; i < WIDTH; i++) begin
      exp_q.push_back(fill_word & WIDTH'((32'h1 << (i + 1)) - 1));
      step(1'b1, 1'b1, '0, fill_word[i], 1'b0, 1'b0);
      check_out("auto_fill_out");
      check("auto_fill_valid", 32'(word_valid), (i == WIDTH - 1) ? 32'h1 : 32'h0);
    end
    check("auto_full_ptr", 32'(ptr), 32'h0);
    check("auto_full_ready", 32'(wr_ready), 32'h0);

    // A 17th write while FULL is ignored.
    exp_q.push_back(16'h3f0a);
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    check_out("full_ignore_out");
    check("full_ignore_ptr", 32'(ptr), 32'h0);

    // The ack releases the word but holds out.
    exp_q.push_back(16'h3f0a);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    check_out("ack_out_held");
    check("ack_valid", 32'(word_valid), 32'h0);
    check("ack_ready", 32'(wr_ready), 32'h1);
    check("ack_ptr", 32'(ptr), 32'h0);
    exp_q.push_back(16'h3f0b);
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    check_out("post_ack_write");
    check("post_ack_ptr", 32'(ptr), 32'h1);

    // Addressed fill and overwrite, starting from a cleared word.
    exp_q.push_back(16'h0000);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_out("clear_out");
    check("clear_ptr", 32'(ptr), 32'h0);
    exp_q.push_back(16'h0002);
    step(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    check_out("addr_sel1");
    exp_q.push_back(16'h0042);
    step(1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0);
    check_out("addr_sel6");
    exp_q.push_back(16'h1042);
    step(1'b1, 1'b0, 4'hc, 1'b1, 1'b0, 1'b0);
    check_out("addr_selc");
    check("addr_valid", 32'(word_valid), 32'h0);
    exp_q.push_back(16'h1002);
    step(1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
    check_out("overwrite_out");
    check("overwrite_still_fill", 32'(wr_ready), 32'h1);
    for (int i = 0; i < WIDTH; i++) begin
      if (i != 1 && i != 6 && i != 12) begin
        exp_q.push_back(16'h1002);
        step(1'b1, 1'b0, SEL_W'(i), 1'b0, 1'b0, 1'b0);
        check_out("addr_rest");
        check("addr_ptr_held", 32'(ptr), 32'h0);
      end
    end
    check("addr_full_valid", 32'(word_valid), 32'h1);
    check("addr_full_ready", 32'(wr_ready), 32'h0);

    // When FULL, an ack and a write in the same cycle: the ack wins and the write is dropped.
    exp_q.push_back(16'h1002);
    step(1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1);
    check_out("ack_vs_write_out");
    check("ack_vs_write_valid", 32'(word_valid), 32'h0);

    // When in FILL, a clear and a write in the same cycle: the clear wins.
    exp_q.push_back(16'h1000);
    step(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
    check_out("fill_before_clear");
    exp_q.push_back(16'h0000);
    step(1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
    check_out("clear_vs_write_out");
    check("clear_vs_write_ptr", 32'(ptr), 32'h0);
    check("clear_vs_write_ready", 32'(wr_ready), 32'h1);

    // Switching mode mid-fill keeps ptr at its last value.
    exp_q.push_back(16'h0001);
    step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    check_out("mode_auto0");
    exp_q.push_back(16'h0021);
    step(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
    check_out("mode_addr5");
    check("mode_ptr_held", 32'(ptr), 32'h1);
    exp_q.push_back(16'h0023);
    step(1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    check_out("mode_auto1");
    check("mode_ptr_adv", 32'(ptr), 32'h2);

    // An ack outside FULL has no effect.
    exp_q.push_back(16'h0023);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_out("ack_in_fill_out");
    check("ack_in_fill_ptr", 32'(ptr), 32'h2);

    // Reset overrides a concurrent write.
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; auto_mode = 1'b1; din = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    exp_q.push_back(16'h0000);
    check_out("rst_vs_write_out");
    check("rst_vs_write_ptr", 32'(ptr), 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
